// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared types and defaults for the MIPS pipeline front end
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
//------------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register with hold (en low) and flush/bubble (clr)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    // A bubble or flush keeps pcplus4 from the last real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.instr   <= NOP_INSTR;
            q.pcplus4 <= 32'h0;
            q.valid   <= 1'b0;
        end else if (en) begin
            if (clr) begin
                q.instr <= NOP_INSTR;
                q.valid <= 1'b0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : MIPS IF stage with instruction-memory handshake and IF/ID reg
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        pcsrc_d,
    input  logic        jump_d,
    input  logic [31:0] pcbranch_d,
    input  logic [31:0] pcjump_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc_f;
    logic [31:0] hold_buf;
    logic [31:0] drain_addr;
    logic [31:0] fetch_addr;

    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        load;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign stall    = stall_f | stall_d;
    assign redirect = (pcsrc_d | jump_d) & ~stall;
    assign target   = jump_d ? pcjump_d : pcbranch_d;
    assign pc_plus4 = pc_f + 32'd4;

    // An instruction is accepted either straight from memory or from the hold buffer.
    assign load = ~redirect & ~stall &
                  (((state == FETCH) & imem_ready) | (state == HELD));

    assign if_id_d.instr   = (state == HELD) ? hold_buf : imem_rdata;
    assign if_id_d.pcplus4 = pc_plus4;
    assign if_id_d.valid   = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (redirect && !imem_ready) begin
                    state_next = DRAIN;
                end else if (!redirect && imem_ready && stall) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (redirect || !stall) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = (state != HELD);
        fetch_addr = (state == DRAIN) ? drain_addr : pc_f;
        imem_addr  = fetch_addr & ~32'h3;
    end

    // pc_f always tracks the next correct-path fetch; a draining request keeps its own address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f       <= RESET_PC;
            hold_buf   <= 32'h0;
            drain_addr <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc_f <= target;
                        if (!imem_ready) begin
                            drain_addr <= pc_f;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            hold_buf <= imem_rdata;
                        end else begin
                            pc_f <= pc_plus4;
                        end
                    end
                end
                HELD: begin
                    if (redirect) begin
                        pc_f <= target;
                    end else if (!stall) begin
                        pc_f <= pc_plus4;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_f <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (~stall),
        .clr   (redirect | ~load),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign instr_d   = if_id_q.instr;
    assign pcplus4_d = if_id_q.pcplus4;
    assign valid_d   = if_id_q.valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage : directed and randomized checks of fetch_stage against a model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        pcsrc_d = 1'b0;
    logic        jump_d = 1'b0;
    logic [31:0] pcbranch_d = 32'h0;
    logic [31:0] pcjump_d = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    fetch_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .pcsrc_d    (pcsrc_d),
        .jump_d     (jump_d),
        .pcbranch_d (pcbranch_d),
        .pcjump_d   (pcjump_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch pointer, an optional parked instruction and an
    // optional in-flight wrong-path request that must be waited out.
    logic [31:0] m_pc, m_buf, m_drain_addr, m_instr, m_pc4;
    bit          m_held, m_drain, m_valid;
    bit          st, redir, acc;
    logic [31:0] tgt, word;

    function automatic logic [31:0] exp_addr();
        return (m_drain ? m_drain_addr : m_pc) & ~32'h3;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = 32'h0; m_buf = 32'h0; m_drain_addr = 32'h0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_held = 1'b0; m_drain = 1'b0;
        end else begin
            st    = stall_f | stall_d;
            redir = (pcsrc_d | jump_d) && !st;
            tgt   = jump_d ? pcjump_d : pcbranch_d;
            acc   = 1'b0;
            word  = 32'h0;
            if (!redir && !st) begin
                if (m_held) begin
                    acc = 1'b1; word = m_buf;
                end else if (!m_drain && imem_ready) begin
                    acc = 1'b1; word = imem_rdata;
                end
            end
            if (redir) begin
                m_instr = 32'h0; m_valid = 1'b0;
            end else if (!st) begin
                if (acc) begin
                    m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_instr = 32'h0; m_valid = 1'b0;
                end
            end
            if (m_drain) begin
                if (imem_ready) m_drain = 1'b0;
            end else if (m_held) begin
                if (redir || acc) m_held = 1'b0;
            end else if (imem_ready && st) begin
                m_held = 1'b1; m_buf = imem_rdata;
            end else if (redir && !imem_ready) begin
                m_drain = 1'b1; m_drain_addr = m_pc;
            end
            if (redir) m_pc = tgt;
            else if (acc) m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("model imem_req",  {31'b0, imem_req}, {31'b0, !m_held});
            chk("model imem_addr", imem_addr, exp_addr());
            chk("model instr_d",   instr_d, m_instr);
            chk("model pcplus4_d", pcplus4_d, m_pc4);
            chk("model valid_d",   {31'b0, valid_d}, {31'b0, m_valid});
        end
    end

    // Drive one cycle of inputs (from negedge+1) and return at the following negedge+1.
    task automatic drive(input logic sf, input logic sd, input logic ps, input logic jp,
                         input logic rdy, input logic [31:0] pb, input logic [31:0] pj,
                         input bit rnd_data);
        stall_f    = sf;
        stall_d    = sd;
        pcsrc_d    = ps;
        jump_d     = jp;
        imem_ready = rdy;
        pcbranch_d = pb;
        pcjump_d   = pj;
        imem_rdata = rnd_data ? $urandom : (32'h1000_0000 | exp_addr());
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, 1'b0, rdy, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset imem_req",  {31'b0, imem_req}, 32'h1);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset valid_d",   {31'b0, valid_d}, 32'h0);
        chk("reset instr_d",   instr_d, 32'h0);
        chk("reset pcplus4_d", pcplus4_d, 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        idle(1'b1);
        chk("stream instr0", instr_d, 32'h1000_0000);
        chk("stream pc4_0",  pcplus4_d, 32'h4);
        chk("stream valid0", {31'b0, valid_d}, 32'h1);
        idle(1'b1);
        chk("stream instr1", instr_d, 32'h1000_0004);
        chk("stream pc4_1",  pcplus4_d, 32'h8);

        idle(1'b0);
        chk("wait addr1",  imem_addr, 32'h8);
        chk("wait valid1", {31'b0, valid_d}, 32'h0);
        idle(1'b0);
        chk("wait addr2",  imem_addr, 32'h8);
        chk("wait valid2", {31'b0, valid_d}, 32'h0);
        idle(1'b1);
        chk("wait instr", instr_d, 32'h1000_0008);
        chk("wait pc4",   pcplus4_d, 32'hC);
        idle(1'b1);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
            chk("held imem_req", {31'b0, imem_req}, 32'h0);
            chk("held instr",    instr_d, 32'h1000_000C);
        end
        idle(1'b1);
        chk("release instr", instr_d, 32'h1000_0010);
        chk("release pc4",   pcplus4_d, 32'h14);
        chk("release addr",  imem_addr, 32'h14);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        chk("branch valid", {31'b0, valid_d}, 32'h0);
        chk("branch addr",  imem_addr, 32'h100);
        idle(1'b1);
        chk("branch instr", instr_d, 32'h1000_0100);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0);
        chk("stalled branch instr", instr_d, 32'h1000_0100);
        chk("stalled branch req",   {31'b0, imem_req}, 32'h0);
        idle(1'b1);
        chk("stalled branch next", instr_d, 32'h1000_0104);
        chk("stalled branch addr", imem_addr, 32'h108);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 1'b0);
        chk("drain addr1",  imem_addr, 32'h108);
        chk("drain valid1", {31'b0, valid_d}, 32'h0);
        idle(1'b0);
        chk("drain addr2",  imem_addr, 32'h108);
        idle(1'b1);
        chk("drain discard", {31'b0, valid_d}, 32'h0);
        chk("drain target",  imem_addr, 32'h200);
        idle(1'b1);
        chk("drain instr", instr_d, 32'h1000_0200);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0);
        idle(1'b1);
        chk("wrap instr", instr_d, 32'hFFFF_FFFC);
        chk("wrap pc4",   pcplus4_d, 32'h0);
        chk("wrap addr",  imem_addr, 32'h0);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 32'h0, 1'b0);
        chk("unaligned addr", imem_addr, 32'h40);
        idle(1'b1);
        chk("unaligned pc4", pcplus4_d, 32'h47);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h3C, 1'b0);
        idle(1'b1);
        chk("pre-reset addr", imem_addr, 32'h40);
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midreset addr",  imem_addr, 32'h0);
        chk("midreset valid", {31'b0, valid_d}, 32'h0);
        chk("midreset instr", instr_d, 32'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("post-reset req",  {31'b0, imem_req}, 32'h1);
        chk("post-reset addr", imem_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3),
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3),
                  1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Sits directly upstream of the hazard unit's decode-stage consumers.
- Owns the PC, issues instruction-memory requests over a ready/req handshake, and buffers a returned instruction while decode is stalled.
- Applies stall_f/stall_d, and branch/jump redirects resolved in decode (pcsrc_d, jump_d).
- Delivers instr_d, pcplus4_d and valid_d to decode; inserts bubbles on memory wait states and redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on bubble/flush (sll $0,$0,0)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
stall_f  in  1  hazard unit: hold PC
stall_d  in  1  hazard unit: hold IF/ID
pcsrc_d  in  1  decode: branch taken
jump_d  in  1  decode: jump
pcbranch_d  in  32  branch target
pcjump_d  in  32  jump target
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch byte address, word aligned
imem_ready  in  1  response valid this cycle; may assert same cycle as req (zero-wait)
imem_rdata  in  32  instruction, valid when imem_ready
instr_d  out  32  IF/ID instruction
pcplus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: single clock; reset is asynchronous and active-low (reset_n). Reset values: pc_f=RESET_PC, state=FETCH, instr_d=NOP_INSTR, pcplus4_d=0, valid_d=0, hold buffer cleared. First cycle after release: imem_req=1, imem_addr=RESET_PC. Reset mid-request abandons it; memory must tolerate this.
- stall = stall_f | stall_d. Both are treated as one effective stall.
- redirect = (pcsrc_d | jump_d) & ~stall. Target = pcjump_d if jump_d, else pcbranch_d. jump_d wins if both are asserted.
- FSM states: FETCH, HELD, DRAIN.
- FETCH: imem_req=1, imem_addr=pc_f.
  - redirect & imem_ready: discard response; pc_f<=target; stay in FETCH.
  - redirect & ~imem_ready: drain_addr<=pc_f; pc_f<=target; go to DRAIN.
  - ~redirect & imem_ready & ~stall: IF/ID<=(imem_rdata, pc_f+4, valid=1); pc_f<=pc_f+4.
  - ~redirect & imem_ready & stall: buf<=imem_rdata; go to HELD. pc_f is not advanced yet.
  - ~imem_ready: pc_f and imem_addr are unchanged. Once raised, req/addr stay stable until ready.
- HELD: imem_req=0.
  - redirect: drop buf; pc_f<=target; go to FETCH.
  - ~stall: IF/ID<=(buf, pc_f+4, 1); pc_f<=pc_f+4; go to FETCH.
  - stall: hold everything.
- DRAIN: imem_req=1, imem_addr=drain_addr.
  - imem_ready: discard response; go to FETCH.
  - A further redirect overwrites pc_f (latest target wins). Drain continues.
- IF/ID update priority, per cycle:
  1. redirect: flush (instr_d=NOP_INSTR, valid_d=0). Wrong-path instruction is killed.
  2. stall: hold all IF/ID fields.
  3. Otherwise load, if an instruction is accepted this cycle.
  4. Otherwise bubble (NOP_INSTR, valid_d=0, pcplus4_d unchanged).
- Timing and arithmetic:
  - Zero-wait memory gives a throughput of 1 instruction/cycle and 1-cycle latency from PC to IF/ID.
  - PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.
  - Targets are taken as given; bits [1:0] are forced to 0 on imem_addr.
- No combinational path from imem_ready to stall outputs; the block produces no stall of its own. Memory wait states appear downstream as bubbles only.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {FETCH, HELD, DRAIN}
  - NOP_INSTR and RESET_PC defaults
  - if_id_t struct {instr, pcplus4, valid}
- One sub-module, if_id_reg: async active-low reset; en (=~stall) and clr (flush/bubble) inputs; clr has priority over en-hold only when redirect is asserted.

Test Plan:
- Reset: hold reset_n=0 mid-stream with pc_f=0x40, release -> imem_addr=0x0, imem_req=1, valid_d=0, instr_d=0.
- Zero-wait stream: imem_ready=1, imem_rdata=0x1000_0000|addr -> instr_d=0x1000_0000,0x1000_0004,0x1000_0008 on consecutive cycles; pcplus4_d=4,8,12; valid_d=1.
- Wait states: imem_ready low 2 cycles at addr 0x8 -> imem_addr stays 0x8, valid_d=0 for 2 cycles, then instr for 0x8 with pcplus4_d=0xC.
- Stall on response: stall_d=1 in the cycle ready returns addr 0x10 -> HELD, imem_req=0, IF/ID unchanged. Release after 3 cycles -> instr_d=word@0x10, next imem_addr=0x14.
- Branch redirect: pcsrc_d=1, pcbranch_d=0x100, zero-wait -> next cycle valid_d=0 and imem_addr=0x100; following cycle instr_d=word@0x100. With stall_d=1 simultaneously -> no redirect, IF/ID held.
- Redirect during wait: ready low at 0x20, jump_d=1, pcjump_d=0x200 -> DRAIN with imem_addr=0x20 until ready; that response is discarded (valid_d=0), then imem_addr=0x200.
